// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ALU operand select with a DEPTH-entry valid/ready FIFO
// Defining ALU_OPSEL_FWD_EN adds writeback forwarding into rs1/rs2 on accept.
`ifndef RISCV_LUI
`define RISCV_LUI         7'b0110111
`endif
`ifndef RISCV_AUIPC
`define RISCV_AUIPC       7'b0010111
`endif
`ifndef RISCV_JAL
`define RISCV_JAL         7'b1101111
`endif
`ifndef RISCV_JALR
`define RISCV_JALR        7'b1100111
`endif
`ifndef RISCV_BRANCH
`define RISCV_BRANCH      7'b1100011
`endif
`ifndef RISCV_LOAD
`define RISCV_LOAD        7'b0000011
`endif
`ifndef RISCV_STORE
`define RISCV_STORE       7'b0100011
`endif
`ifndef RISCV_ALU_OP_IMM
`define RISCV_ALU_OP_IMM  7'b0010011
`endif
`ifndef RISCV_ALU_OP_REGS
`define RISCV_ALU_OP_REGS 7'b0110011
`endif

module alu_operand_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] pc_value,
   input  logic [XLEN-1:0] immediate,
`ifdef ALU_OPSEL_FWD_EN
   input  logic [4:0]      rs1_idx,
   input  logic [4:0]      rs2_idx,
   input  logic            fwd_valid,
   input  logic [4:0]      fwd_rd,
   input  logic [XLEN-1:0] fwd_data,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   output logic            illegal
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] src1, src2;
   logic [XLEN-1:0] sel1, sel2;
   logic            sel_ill;

   logic [XLEN-1:0] mem1    [DEPTH];
   logic [XLEN-1:0] mem2    [DEPTH];
   logic            mem_ill [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count;
   logic            push, pop;

`ifdef ALU_OPSEL_FWD_EN
   // x0 is hardwired zero, so a write to rd=0 must never be forwarded.
   always_comb begin
      src1 = rs1;
      src2 = rs2;
      if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs1_idx)) src1 = fwd_data;
      if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs2_idx)) src2 = fwd_data;
   end
`else
   assign src1 = rs1;
   assign src2 = rs2;
`endif

   always_comb begin
      sel1    = '0;
      sel2    = '0;
      sel_ill = 1'b0;
      case (opcode)
         `RISCV_AUIPC: begin
            sel1 = pc_value;
            sel2 = immediate;
         end
         `RISCV_LUI: sel2 = immediate;
         `RISCV_ALU_OP_REGS, `RISCV_BRANCH: begin
            sel1 = src1;
            sel2 = src2;
         end
         `RISCV_ALU_OP_IMM, `RISCV_LOAD, `RISCV_STORE: begin
            sel1 = src1;
            sel2 = immediate;
         end
         `RISCV_JAL, `RISCV_JALR: begin
            sel1 = pc_value;
            sel2 = XLEN'(4);
         end
         default: sel_ill = 1'b1;
      endcase
   end

   // Ready depends only on the registered count, never on out_ready.
   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem1[i]    <= '0;
            mem2[i]    <= '0;
            mem_ill[i] <= 1'b0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem1[wr_ptr]    <= sel1;
            mem2[wr_ptr]    <= sel2;
            mem_ill[wr_ptr] <= sel_ill;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   assign alu_in1 = mem1[rd_ptr];
   assign alu_in2 = mem2[rd_ptr];
   assign illegal = mem_ill[rd_ptr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized and directed bench for alu_operand_stage against a queue model
module tb_alu_operand_stage;
   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [6:0]      opcode = 7'h33;
   logic [XLEN-1:0] rs1 = '0, rs2 = '0, pc_value = '0, immediate = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] alu_in1, alu_in2;
   logic            illegal;
`ifdef ALU_OPSEL_FWD_EN
   logic [4:0]      rs1_idx = '0, rs2_idx = '0, fwd_rd = '0;
   logic            fwd_valid = 1'b0;
   logic [XLEN-1:0] fwd_data = '0;
`endif

   int checks = 0;
   int errors = 0;
   logic [2*XLEN:0] model_q [$];
   logic [6:0] op_table [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};

   always #5 clk = ~clk;

   alu_operand_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .rs1(rs1), .rs2(rs2), .pc_value(pc_value), .immediate(immediate),
`ifdef ALU_OPSEL_FWD_EN
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .illegal(illegal)
   );

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected {in1, in2, illegal} for the current input signals.
   function automatic logic [2*XLEN:0] ref_entry();
      logic [XLEN-1:0] a, b;
      a = rs1;
      b = rs2;
`ifdef ALU_OPSEL_FWD_EN
      if (fwd_valid && fwd_rd != 0 && fwd_rd == rs1_idx) a = fwd_data;
      if (fwd_valid && fwd_rd != 0 && fwd_rd == rs2_idx) b = fwd_data;
`endif
      case (opcode)
         7'h17:               return {pc_value, immediate, 1'b0};
         7'h37:               return {{XLEN{1'b0}}, immediate, 1'b0};
         7'h33, 7'h63:        return {a, b, 1'b0};
         7'h13, 7'h03, 7'h23: return {a, immediate, 1'b0};
         7'h6F, 7'h67:        return {pc_value, XLEN'(4), 1'b0};
         default:             return {{(2*XLEN){1'b0}}, 1'b1};
      endcase
   endfunction

   task automatic model_check(input string tag);
      chk({tag, "_out_valid"}, XLEN'(out_valid), XLEN'(model_q.size() != 0));
      chk({tag, "_in_ready"}, XLEN'(in_ready), XLEN'(model_q.size() < DEPTH));
      if (model_q.size() != 0) begin
         chk({tag, "_alu_in1"}, alu_in1, model_q[0][2*XLEN:XLEN+1]);
         chk({tag, "_alu_in2"}, alu_in2, model_q[0][XLEN:1]);
         chk({tag, "_illegal"}, XLEN'(illegal), XLEN'(model_q[0][0]));
      end
   endtask

   // One clock: model decides push/pop from its own occupancy, then compares at the negedge.
   task automatic step(input string tag);
      bit acc, deq;
      logic [2*XLEN:0] e;
      acc = in_valid && (model_q.size() < DEPTH);
      deq = out_ready && (model_q.size() != 0);
      e = ref_entry();
      @(posedge clk);
      if (flush) model_q.delete();
      else begin
         if (deq) void'(model_q.pop_front());
         if (acc) model_q.push_back(e);
      end
      @(negedge clk);
      model_check(tag);
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
      in_valid = v; opcode = op; rs1 = a; rs2 = b; pc_value = pc; immediate = imm;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_out_valid", XLEN'(out_valid), 0);
      chk("reset_in_ready", XLEN'(in_ready), 1);
      chk("reset_alu_in1", alu_in1, 0);
      chk("reset_alu_in2", alu_in2, 0);
      chk("reset_illegal", XLEN'(illegal), 0);
      rst_n = 1'b1;

      out_ready = 1'b1;
      drive(1, 7'h33, 5, 7, 0, 0);
      step("op_regs");
      chk("op_regs_in1", alu_in1, 5);
      chk("op_regs_in2", alu_in2, 7);
      chk("op_regs_ill", XLEN'(illegal), 0);

      drive(1, 7'h17, 0, 0, 32'h100, 32'h2000);
      step("auipc");
      chk("auipc_in1", alu_in1, 32'h100);
      chk("auipc_in2", alu_in2, 32'h2000);
      drive(1, 7'h6F, 0, 0, 32'h104, 32'h55);
      step("jal");
      chk("jal_in1", alu_in1, 32'h104);
      chk("jal_in2", alu_in2, 4);
      drive(0, 7'h33, 0, 0, 0, 0);
      step("drain0");

      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive(1, 7'h33, XLEN'(i), 32'hA0 + XLEN'(i), 0, 0);
         step("bp_fill");
         if (i == 2) chk("bp_full_in_ready", XLEN'(in_ready), 0);
      end
      chk("bp_head_first", alu_in1, 1);
      out_ready = 1'b1;
      step("bp_pop1");
      chk("bp_head_second", alu_in1, 2);
      step("bp_pop2");
      chk("bp_third_accepted", alu_in1, 3);
      drive(0, 7'h33, 0, 0, 0, 0);
      step("bp_drain");

      drive(1, 7'h7F, 32'h1234, 32'h5678, 32'h9A, 32'hBC);
      step("illegal");
      chk("illegal_in1", alu_in1, 0);
      chk("illegal_in2", alu_in2, 0);
      chk("illegal_flag", XLEN'(illegal), 1);

      out_ready = 1'b0;
      drive(1, 7'h13, 32'h11, 0, 0, 32'h22);
      step("fl_fill1");
      drive(1, 7'h03, 32'h33, 0, 0, 32'h44);
      step("fl_fill2");
      flush = 1'b1;
      drive(1, 7'h33, 32'h99, 32'h98, 0, 0);
      step("flush");
      chk("flush_out_valid", XLEN'(out_valid), 0);
      flush = 1'b0;
      drive(0, 7'h33, 0, 0, 0, 0);
      step("post_flush");

`ifdef ALU_OPSEL_FWD_EN
      rs1_idx = 5'd3; fwd_rd = 5'd3; fwd_valid = 1'b1; fwd_data = 32'hAA;
      out_ready = 1'b1;
      drive(1, 7'h33, 32'h11, 32'h12, 0, 0);
      step("fwd_hit");
      chk("fwd_hit_in1", alu_in1, 32'hAA);
      rs1_idx = 5'd0; fwd_rd = 5'd0;
      step("fwd_x0");
      chk("fwd_x0_in1", alu_in1, 32'h11);
      fwd_valid = 1'b0;
      drive(0, 7'h33, 0, 0, 0, 0);
      step("fwd_drain");
`endif

      for (int n = 0; n < 400; n++) begin
         flush = ($urandom_range(0, 15) == 0);
         out_ready = $urandom_range(0, 2) != 0;
         drive($urandom_range(0, 3) != 0, op_table[$urandom_range(0, 9)],
               $urandom, $urandom, $urandom, $urandom);
         if ($urandom_range(0, 9) == 0) opcode = 7'($urandom);
`ifdef ALU_OPSEL_FWD_EN
         rs1_idx = 5'($urandom_range(0, 3));
         rs2_idx = 5'($urandom_range(0, 3));
         fwd_rd = 5'($urandom_range(0, 3));
         fwd_valid = $urandom_range(0, 1) != 0;
         fwd_data = $urandom;
`endif
         step("rand");
      end
      flush = 1'b0;

      out_ready = 1'b0;
      drive(1, 7'h37, 0, 0, 0, 32'hF00D);
      step("ar_fill");
      #2 rst_n = 1'b0;
      #1;
      model_q.delete();
      chk("async_rst_out_valid", XLEN'(out_valid), 0);
      chk("async_rst_in_ready", XLEN'(in_ready), 1);
      chk("async_rst_alu_in2", alu_in2, 0);
      chk("async_rst_illegal", XLEN'(illegal), 0);
      #1 rst_n = 1'b1;
      drive(0, 7'h33, 0, 0, 0, 0);
      step("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
